// File: rtl/multicycle_datapath_controller.sv
// Multi-cycle MIPS control FSM: walks each instruction through fetch, decode,
// execute, memory and writeback, with a timed request/ack memory handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no instruction in flight; waits for Run
// FETCH     | instruction read; opcode latched and PC/IR loaded on MemAck
// DECODE    | one cycle to classify the latched opcode; flags illegal ones
// EXECUTE   | ALU operand/operation select (ALU op or lw/sw address calc)
// MEM       | data read (lw) or write (sw) with the same handshake as FETCH
// WRITEBACK | register file write from ALU result or loaded data
// BRANCH    | beq compare; datapath gates the PC update with Zero
// FAULT     | memory never answered; sticky until reset
module multicycle_datapath_controller #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                MemAck,
  output logic                MemReq,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                AluSrc,
  output logic                MemWrite,
  output logic                MemRead,
  output logic                Branch,
  output logic                MemToReg,
  output logic                SignExt,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                InstrDone,
  output logic                Illegal,
  output logic                Fault
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_BRANCH    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic       dec_legal;
  logic       dec_beq;
  logic       dec_lw;
  logic       dec_sw;
  logic       dec_reg_dst;
  logic       dec_alu_src;
  logic       dec_sign_ext;
  logic       dec_mem_to_reg;
  logic [3:0] dec_alu_op;
  logic [5:0] op6;
  logic       upper_zero;
  logic       timeout_hit;

  assign op6         = opcode_q[5:0];
  assign upper_zero  = ((opcode_q >> 6) == '0);
  assign timeout_hit = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Opcode decode from the latched instruction only, so every control is
  // stable for the whole state it belongs to.
  always_comb begin
    dec_legal      = 1'b1;
    dec_beq        = 1'b0;
    dec_lw         = 1'b0;
    dec_sw         = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_sign_ext   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_op     = 4'b0000;
    case (op6)
      6'b000000: begin dec_sign_ext = 1'b1; dec_alu_op = 4'b0000; end
      6'b011100: begin dec_sign_ext = 1'b1; dec_alu_op = 4'b1100; end
      6'b011111: begin dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 4'b0000; end
      6'b001001: begin dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 4'b0111; end
      6'b001000: begin
        dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_sign_ext = 1'b1; dec_alu_op = 4'b0001;
      end
      6'b001100: begin dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 4'b0100; end
      6'b001101: begin dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 4'b0011; end
      6'b001110: begin dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 4'b0101; end
      6'b001010: begin
        dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_sign_ext = 1'b1; dec_alu_op = 4'b1010;
      end
      6'b001011: begin
        dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_sign_ext = 1'b1; dec_alu_op = 4'b1011;
      end
      6'b100011: begin
        dec_lw = 1'b1; dec_reg_dst = 1'b1; dec_alu_src = 1'b1; dec_sign_ext = 1'b1;
        dec_mem_to_reg = 1'b1; dec_alu_op = 4'b0001;
      end
      6'b101011: begin
        dec_sw = 1'b1; dec_alu_src = 1'b1; dec_sign_ext = 1'b1; dec_alu_op = 4'b0001;
      end
      6'b000100: dec_beq = 1'b1;
      default:   dec_legal = 1'b0;
    endcase
    if (!upper_zero) begin
      dec_legal = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // The timeout counter only survives a cycle while a request is unanswered;
  // every other path falls through to the cleared default.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = '0;
    MemReq    = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    AluSrc    = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Branch    = 1'b0;
    MemToReg  = 1'b0;
    SignExt   = 1'b0;
    AluOp     = '0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    Fault     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        // PC/IR load is qualified by the ack itself so it lands in the same
        // cycle the instruction word is on the bus.
        if (MemAck) begin
          opcode_d = OpCode;
          PCWrite  = 1'b1;
          IRWrite  = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          Illegal   = 1'b1;
          InstrDone = 1'b1;
          state_d   = Run ? S_FETCH : S_IDLE;
        end else if (dec_beq) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        AluSrc  = dec_alu_src;
        SignExt = dec_sign_ext;
        AluOp   = ALUOP_W'(dec_alu_op);
        state_d = (dec_lw || dec_sw) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemRead  = dec_lw;
        MemWrite = dec_sw;
        if (MemAck) begin
          if (dec_sw) begin
            InstrDone = 1'b1;
            state_d   = Run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITEBACK: begin
        RegWrite  = 1'b1;
        RegDst    = dec_reg_dst;
        MemToReg  = dec_mem_to_reg;
        InstrDone = 1'b1;
        state_d   = Run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        AluOp     = ALUOP_W'(4'b0010);
        InstrDone = 1'b1;
        state_d   = Run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_datapath_controller.sv
// Scoreboard bench: stimulus queues expected per-cycle output vectors, a
// negedge monitor compares them against the DUT and flags unexpected activity.
module tb_multicycle_datapath_controller;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Run = 1'b0;
  logic       MemAck = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic       MemReq, RegDst, RegWrite, AluSrc, MemWrite, MemRead, Branch;
  logic       MemToReg, SignExt, PCWrite, IRWrite, InstrDone, Illegal, Fault;
  logic [3:0] AluOp;

  always #5 Clk = ~Clk;

  multicycle_datapath_controller #(
    .OPCODE_W(6), .ALUOP_W(4), .MEM_TIMEOUT(15)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .OpCode(OpCode), .MemAck(MemAck),
    .MemReq(MemReq), .RegDst(RegDst), .RegWrite(RegWrite), .AluSrc(AluSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch), .MemToReg(MemToReg),
    .SignExt(SignExt), .AluOp(AluOp), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .InstrDone(InstrDone), .Illegal(Illegal), .Fault(Fault)
  );

  localparam logic [17:0] B_REQ  = 18'd1 << 17;
  localparam logic [17:0] B_RD   = 18'd1 << 16;
  localparam logic [17:0] B_WR   = 18'd1 << 15;
  localparam logic [17:0] B_PCW  = 18'd1 << 14;
  localparam logic [17:0] B_IRW  = 18'd1 << 13;
  localparam logic [17:0] B_RDST = 18'd1 << 12;
  localparam logic [17:0] B_RW   = 18'd1 << 11;
  localparam logic [17:0] B_ASRC = 18'd1 << 10;
  localparam logic [17:0] B_SEXT = 18'd1 << 9;
  localparam logic [17:0] B_M2R  = 18'd1 << 8;
  localparam logic [17:0] B_BR   = 18'd1 << 7;
  localparam logic [17:0] B_DONE = 18'd1 << 2;
  localparam logic [17:0] B_ILL  = 18'd1 << 1;
  localparam logic [17:0] B_FLT  = 18'd1;
  localparam logic [17:0] F_ACK  = B_REQ | B_RD | B_PCW | B_IRW;
  localparam logic [17:0] F_WAIT = B_REQ | B_RD;

  function automatic logic [17:0] aop(input logic [3:0] o);
    return {11'd0, o, 3'd0};
  endfunction

  typedef struct {
    int          cyc;
    logic [17:0] vec;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   ack_q[$];
  int   cyc = 0;
  int   base = 0;
  int   tests = 0;
  int   fails = 0;
  logic finish_req = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory responder: each new request episode takes its ack delay from
  // ack_q (0 = same cycle, -1 = never answer).
  always begin : responder
    int   wait_left;
    logic in_req;
    @(posedge Clk);
    #2;
    if (MemReq) begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_left = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
      end
      if (wait_left == 0) begin
        MemAck = 1'b1;
        in_req = 1'b0;
      end else begin
        MemAck = 1'b0;
        if (wait_left > 0) wait_left--;
      end
    end else begin
      MemAck = 1'b0;
      in_req = 1'b0;
    end
  end

  always @(negedge Clk) begin : monitor
    logic [17:0] v;
    v = {MemReq, MemRead, MemWrite, PCWrite, IRWrite, RegDst, RegWrite, AluSrc,
         SignExt, MemToReg, Branch, AluOp, InstrDone, Illegal, Fault};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL %s: no check reached for cycle %0d (now %0d)", sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      tests++;
      if (v !== sb[0].vec) begin
        fails++;
        $display("FAIL %s @cyc %0d: got %b expected %b", sb[0].name, cyc, v, sb[0].vec);
      end
      void'(sb.pop_front());
    end else if (v !== 18'd0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_output @cyc %0d: got %b expected all zero", cyc, v);
    end
    if (finish_req) begin
      while (sb.size() > 0) begin
        tests++;
        fails++;
        $display("FAIL %s: never compared (cycle %0d)", sb[0].name, sb[0].cyc);
        void'(sb.pop_front());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic exp_at(input int off, input logic [17:0] v, input string nm);
    exp_t e;
    e.cyc  = base + off;
    e.vec  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic start(input logic [5:0] op);
    OpCode = op;
    Run    = 1'b1;
    base   = cyc;
  endtask

  typedef struct {
    logic [5:0] op;
    logic       rdst, asrc, sext;
    logic [3:0] alu;
    string      name;
  } itype_t;

  itype_t itab[8];

  initial begin
    itab[0] = '{6'b011100, 1'b0, 1'b0, 1'b1, 4'b1100, "mul"};
    itab[1] = '{6'b011111, 1'b1, 1'b1, 1'b0, 4'b0000, "seh"};
    itab[2] = '{6'b001001, 1'b1, 1'b1, 1'b0, 4'b0111, "addiu"};
    itab[3] = '{6'b001100, 1'b1, 1'b1, 1'b0, 4'b0100, "andi"};
    itab[4] = '{6'b001101, 1'b1, 1'b1, 1'b0, 4'b0011, "ori"};
    itab[5] = '{6'b001110, 1'b1, 1'b1, 1'b0, 4'b0101, "xori"};
    itab[6] = '{6'b001010, 1'b1, 1'b1, 1'b1, 4'b1010, "slti"};
    itab[7] = '{6'b001011, 1'b1, 1'b1, 1'b1, 4'b1011, "sltiu"};

    // Reset held, then released with Run low: nothing may move.
    base = 0;
    exp_at(1, 18'd0, "reset_outputs");
    exp_at(2, 18'd0, "reset_outputs");
    step(3);
    Rst  = 1'b1;
    base = cyc;
    exp_at(1, 18'd0, "idle_run_low");
    exp_at(2, 18'd0, "idle_run_low");
    step(3);

    // addi -> illegal 111111 -> R-type with Run dropped, back to back.
    start(6'b001000);
    exp_at(1, F_ACK, "addi_fetch");
    exp_at(2, 18'd0, "addi_decode");
    exp_at(3, B_ASRC | B_SEXT | aop(4'b0001), "addi_exec");
    exp_at(4, B_RDST | B_RW | B_DONE, "addi_wb");
    exp_at(5, F_ACK, "refetch_after_addi");
    exp_at(6, B_ILL | B_DONE, "illegal_decode");
    exp_at(7, F_ACK, "fetch_after_illegal");
    exp_at(8, 18'd0, "rtype_decode");
    exp_at(9, B_SEXT | aop(4'b0000), "rtype_exec");
    exp_at(10, B_RW | B_DONE, "rtype_wb");
    exp_at(11, 18'd0, "idle_after_rtype");
    exp_at(12, 18'd0, "idle_after_rtype");
    step(4);
    OpCode = 6'b111111;
    step(2);
    OpCode = 6'b000000;
    step(2);
    Run = 1'b0;
    step(5);

    // lw with the data ack delayed 3 cycles: 8-cycle instruction.
    ack_q.push_back(0);
    ack_q.push_back(3);
    start(6'b100011);
    exp_at(1, F_ACK, "lw_fetch");
    exp_at(2, 18'd0, "lw_decode");
    exp_at(3, B_ASRC | B_SEXT | aop(4'b0001), "lw_exec");
    for (int i = 4; i <= 7; i++) exp_at(i, F_WAIT, "lw_mem_wait");
    exp_at(8, B_RDST | B_RW | B_M2R | B_DONE, "lw_wb");
    exp_at(9, 18'd0, "idle_after_lw");
    step(2);
    Run = 1'b0;
    step(8);

    // sw, immediate acks.
    start(6'b101011);
    exp_at(1, F_ACK, "sw_fetch");
    exp_at(2, 18'd0, "sw_decode");
    exp_at(3, B_ASRC | B_SEXT | aop(4'b0001), "sw_exec");
    exp_at(4, B_REQ | B_WR | B_DONE, "sw_mem");
    exp_at(5, 18'd0, "idle_after_sw");
    step(2);
    Run = 1'b0;
    step(4);

    // beq, Run dropped during BRANCH.
    start(6'b000100);
    exp_at(1, F_ACK, "beq_fetch");
    exp_at(2, 18'd0, "beq_decode");
    exp_at(3, B_BR | aop(4'b0010) | B_DONE, "beq_branch");
    exp_at(4, 18'd0, "idle_after_beq");
    exp_at(5, 18'd0, "idle_after_beq");
    step(3);
    Run = 1'b0;
    step(3);

    // Remaining I-type and special opcodes through the decode table.
    for (int k = 0; k < 8; k++) begin
      start(itab[k].op);
      exp_at(1, F_ACK, {itab[k].name, "_fetch"});
      exp_at(2, 18'd0, {itab[k].name, "_decode"});
      exp_at(3, (itab[k].asrc ? B_ASRC : 18'd0) | (itab[k].sext ? B_SEXT : 18'd0) | aop(itab[k].alu),
             {itab[k].name, "_exec"});
      exp_at(4, (itab[k].rdst ? B_RDST : 18'd0) | B_RW | B_DONE, {itab[k].name, "_wb"});
      exp_at(5, 18'd0, {itab[k].name, "_idle"});
      step(2);
      Run = 1'b0;
      step(4);
    end

    // Ack on the last request cycle before timeout must still be accepted.
    ack_q.push_back(14);
    start(6'b000000);
    for (int i = 1; i <= 14; i++) exp_at(i, F_WAIT, "late_ack_wait");
    exp_at(15, F_ACK, "late_ack_fetch");
    exp_at(16, 18'd0, "late_ack_decode");
    exp_at(17, B_SEXT, "late_ack_exec");
    exp_at(18, B_RW | B_DONE, "late_ack_wb");
    exp_at(19, 18'd0, "late_ack_idle");
    step(16);
    Run = 1'b0;
    step(4);

    // Long waits in both FETCH and MEM: the counter restarts per phase.
    ack_q.push_back(10);
    ack_q.push_back(10);
    start(6'b100011);
    for (int i = 1; i <= 10; i++) exp_at(i, F_WAIT, "lw2_fetch_wait");
    exp_at(11, F_ACK, "lw2_fetch");
    exp_at(12, 18'd0, "lw2_decode");
    exp_at(13, B_ASRC | B_SEXT | aop(4'b0001), "lw2_exec");
    for (int i = 14; i <= 24; i++) exp_at(i, F_WAIT, "lw2_mem_wait");
    exp_at(25, B_RDST | B_RW | B_M2R | B_DONE, "lw2_wb");
    exp_at(26, 18'd0, "lw2_idle");
    step(12);
    Run = 1'b0;
    step(15);

    // Reset in the middle of an lw MEM request.
    ack_q.push_back(0);
    ack_q.push_back(5);
    start(6'b100011);
    exp_at(1, F_ACK, "rst_lw_fetch");
    exp_at(2, 18'd0, "rst_lw_decode");
    exp_at(3, B_ASRC | B_SEXT | aop(4'b0001), "rst_lw_exec");
    exp_at(4, F_WAIT, "rst_lw_mem");
    exp_at(5, F_WAIT, "rst_lw_mem");
    for (int i = 6; i <= 10; i++) exp_at(i, 18'd0, "reset_mid_mem");
    step(6);
    Rst = 1'b0;
    Run = 1'b0;
    step(2);
    Rst = 1'b1;
    step(3);

    // Fetch never acknowledged: 15 request cycles, then sticky FAULT.
    ack_q.push_back(-1);
    start(6'b000000);
    for (int i = 1; i <= 15; i++) exp_at(i, F_WAIT, "timeout_wait");
    for (int i = 16; i <= 19; i++) exp_at(i, B_FLT, "fault_sticky");
    for (int i = 20; i <= 23; i++) exp_at(i, 18'd0, "fault_cleared");
    step(20);
    Rst = 1'b0;
    Run = 1'b0;
    step(1);
    Rst = 1'b1;
    step(3);

    step(2);
    finish_req = 1'b1;
  end

endmodule
